// File: rtl/conv_sdiv_seq_16_12_if.sv
// Operand/result bundle for the sequential signed divider.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1.
// The source holds valid and payload steady until that edge.
// The sink may change ready at any time.
interface conv_sdiv_seq_16_12_if #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 12
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/conv_sdiv_seq_16_12.sv
// Sequential signed divider: radix-2 restoring core on magnitudes, one quotient bit per cycle.
// Signs and the divide-by-zero / MIN/-1 cases are applied in a single fix-up cycle.
module conv_sdiv_seq_16_12 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 12
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    conv_sdiv_seq_16_12_if.slave        s_bus,
    output logic [1:0]                  o_state
);
    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] Q_MAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] Q_MIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [REM_W-1:0]      r_rem;
    logic [REM_W-1:0]      r_dvs;
    logic                  r_dvd_neg;
    logic                  r_dvs_neg;
    logic                  r_zero;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_cnt;

    logic                  r_out_valid;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_dbz;
    logic                  r_ovf_flag;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [DIVIDEND_W-1:0] w_dvd_abs;
    logic [REM_W-1:0]      w_dvs_ext;
    logic [REM_W-1:0]      w_dvs_abs;
    logic [REM_W:0]        w_shift;
    logic [REM_W:0]        w_trial;
    logic                  w_ge;
    logic [DIVIDEND_W-1:0] w_q_signed;
    logic [DIVISOR_W-1:0]  w_r_signed;
    logic [DIVIDEND_W-1:0] w_q_fix;
    logic [DIVISOR_W-1:0]  w_r_fix;

    assign w_in_ready = (r_state == S_IDLE) & ap_rst_n;
    assign w_accept   = s_bus.in_valid & w_in_ready;

    // |MIN| = 2^(W-1) is exact as an unsigned W-bit value, so no extra bit is kept.
    assign w_dvd_abs = s_bus.dividend[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - s_bus.dividend)
                                                    : s_bus.dividend;
    assign w_dvs_ext = {s_bus.divisor[DIVISOR_W-1], s_bus.divisor};
    assign w_dvs_abs = w_dvs_ext[REM_W-1] ? (REM_W'(0) - w_dvs_ext) : w_dvs_ext;

    assign w_shift = {r_rem, r_quo[DIVIDEND_W-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_trial[REM_W];

    assign w_q_signed = (r_dvd_neg ^ r_dvs_neg) ? (DIVIDEND_W'(0) - r_quo) : r_quo;
    assign w_r_signed = r_dvd_neg ? (DIVISOR_W'(0) - r_rem[DIVISOR_W-1:0]) : r_rem[DIVISOR_W-1:0];
    assign w_q_fix    = r_zero ? (r_dvd_neg ? Q_MIN : Q_MAX) : (r_ovf ? Q_MAX : w_q_signed);
    assign w_r_fix    = (r_zero | r_ovf) ? '0 : w_r_signed;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (r_out_valid & s_bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_ovf_flag  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FIX) begin
                r_out_valid <= 1'b1;
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
                r_dbz       <= r_zero;
                r_ovf_flag  <= r_ovf;
            end else if ((r_state == S_DONE) && s_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Datapath needs no reset: it is always reloaded at the accepting edge.
    always_ff @(posedge ap_clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    r_quo     <= w_dvd_abs;
                    r_dvs     <= w_dvs_abs;
                    r_rem     <= '0;
                    r_dvd_neg <= s_bus.dividend[DIVIDEND_W-1];
                    r_dvs_neg <= s_bus.divisor[DIVISOR_W-1];
                    r_zero    <= (s_bus.divisor == '0);
                    r_ovf     <= (s_bus.dividend == Q_MIN) && (s_bus.divisor == '1);
                    r_cnt     <= CNT_W'(DIVIDEND_W - 1);
                end
            end
            S_CALC: begin
                r_rem <= w_ge ? w_trial[REM_W-1:0] : w_shift[REM_W-1:0];
                r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
                r_cnt <= r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    assign s_bus.in_ready    = w_in_ready;
    assign s_bus.out_valid   = r_out_valid;
    assign s_bus.quotient    = r_quotient;
    assign s_bus.remainder   = r_remainder;
    assign s_bus.div_by_zero = r_dbz;
    assign s_bus.overflow    = r_ovf_flag;
    assign o_state           = r_state;
endmodule

// File: tb/tb_conv_sdiv_seq_16_12.sv
// Bench for conv_sdiv_seq_16_12: directed corner cases, then randomized traffic
// scored against C-style integer division computed with plain int arithmetic.
module tb_conv_sdiv_seq_16_12;
    localparam int W = 16;
    localparam int DW = 12;
    localparam int N_RAND = 1500;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic [1:0] dbg_state;

    conv_sdiv_seq_16_12_if #(.DIVIDEND_W(W), .DIVISOR_W(DW)) bus ();

    conv_sdiv_seq_16_12 #(.DIVIDEND_W(W), .DIVISOR_W(DW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_bus    (bus),
        .o_state  (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;
    // Packed result word: {overflow, div_by_zero, remainder, quotient}
    logic [29:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [29:0] ref_div(input int a, input int b);
        int q;
        int r;
        logic dz;
        logic ov;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = (a >= 0) ? 32767 : -32768;
            r = 0;
            dz = 1'b1;
        end else if (a == -32768 && b == -1) begin
            q = 32767;
            r = 0;
            ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {ov, dz, 12'(r), 16'(q)};
    endfunction

    function automatic logic [29:0] dut_word();
        return {bus.overflow, bus.div_by_zero, bus.remainder, bus.quotient};
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) tick();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_word", 32'(dut_word()), 0);
        ap_rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 1);
    endtask

    // Latency counts edges with the accepting edge as edge 1.
    task automatic run_op(input int a, input int b, input int hold);
        int lat;
        int g;
        logic [29:0] exp;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        bus.dividend = 16'(a);
        bus.divisor  = 12'(b);
        bus.in_valid = 1'b1;
        exp_q.push_back(ref_div(a, b));
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        check($sformatf("busy %0d/%0d", a, b), 32'(bus.in_ready), 0);
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check($sformatf("lat %0d/%0d", a, b), 32'(lat), 18);
        exp = exp_q.pop_front();
        check($sformatf("res %0d/%0d", a, b), 32'(dut_word()), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 16'($urandom);
            bus.divisor  = 12'($urandom);
            tick();
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_word", 32'(dut_word()), 32'(exp));
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("ack_out_valid", 32'(bus.out_valid), 0);
        check("ack_in_ready", 32'(bus.in_ready), 1);
    endtask

    task automatic abort_op();
        int seen;
        bus.dividend = 16'(1234);
        bus.divisor  = 12'(5);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        ap_rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 0);
        repeat (2) tick();
        check("abort_out_valid", 32'(bus.out_valid), 0);
        ap_rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        bus.out_ready = 1'b0;
        check("abort_no_result", 32'(seen), 0);
    endtask

    task automatic rand_driver();
        for (int k = 0; k < N_RAND; k++) begin
            logic signed [15:0] a16;
            logic signed [11:0] b12;
            int   sel;
            int   g;
            logic acc;
            repeat ($urandom_range(0, 3)) tick();
            sel = $urandom_range(0, 9);
            a16 = (sel == 0) ? 16'sh8000 : (sel == 1) ? 16'sh7fff : 16'($urandom);
            sel = $urandom_range(0, 11);
            case (sel)
                0: b12 = 12'sd0;
                1: b12 = -12'sd1;
                2: b12 = 12'sd1;
                3: b12 = 12'sh800;
                4, 5: b12 = 12'($urandom_range(0, 16)) - 12'sd8;
                default: b12 = 12'($urandom);
            endcase
            bus.dividend = a16;
            bus.divisor  = b12;
            bus.in_valid = 1'b1;
            g = 0;
            acc = 1'b0;
            while (!acc && g < 200) begin
                acc = bus.in_ready;
                tick();
                g++;
            end
            bus.in_valid = 1'b0;
            if (acc) exp_q.push_back(ref_div(int'(a16), int'(b12)));
            else check("drv_accept_timeout", 0, 1);
        end
    endtask

    task automatic rand_monitor();
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < N_RAND && cyc < N_RAND * 40) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("rand_unexpected", 1, 0);
                else check($sformatf("rand #%0d", got), 32'(dut_word()), 32'(exp_q.pop_front()));
                got++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("rand_count", 32'(got), 32'(N_RAND));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        run_op(100, 7, 0);
        run_op(-100, 7, 0);
        run_op(100, -7, 0);
        run_op(-100, -7, 0);
        run_op(5, 0, 0);
        run_op(-5, 0, 0);
        run_op(0, 0, 0);
        run_op(-32768, -1, 0);
        run_op(-32768, 1, 0);
        run_op(32767, -2048, 0);
        run_op(37, -4, 10);
        abort_op();
        run_op(1000, -3, 0);
        fork
            rand_driver();
            rand_monitor();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
